voq_scheduler: RTL and testbench

VOQ_SCHEDULER -- requirements
Module: voq_scheduler

---
 rtl/voq_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_voq_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : voq_scheduler (with companion packages mem_pkg, voq_pkg)
//  Description : Round-robin dequeue scheduler for NUM_PORTS virtual output
//                queues. It shadows each VOQ's occupancy by snooping the VOQ
//                write strobes. It picks the next non-empty VOQ from a rotating
//                pointer, issues a single-cycle read, captures the returned
//                buffer pointer and presents it to egress with a valid/ready
//                handshake.
//
//  Ports
//    clk              : single clock, rising edge
//    rst              : synchronous active-high reset (issue together with
//                       the VOQs' own reset)
//    voq_write_req_i  : [NUM_PORTS]        snoop of each VOQ's write strobe
//    voq_read_req_o   : [NUM_PORTS]        one-hot read request to a VOQ
//    voq_ptr_i        : [NUM_PORTS*ADDR_W] VOQ k head pointer at [k*ADDR_W +: ADDR_W]
//    voq_ptr_valid_i  : [NUM_PORTS]        VOQ k head pointer valid
//    ptr_o            : [ADDR_W]           dequeued pointer to egress
//    port_o           : [clog2(NUM_PORTS)] source VOQ index of ptr_o
//    valid_o          : ptr_o/port_o valid
//    ready_i          : egress accepts when valid_o && ready_i
//    err_cnt_o        : [8] saturating underrun count
//
//  Build option
//    VOQ_SCHED_UNDERRUN_CNT_EN : when defined, err_cnt_o counts capture
//                                underruns (saturating at 8'hFF); otherwise
//                                it is tied to zero and no counter exists.
//
//  Revision    : 1.0 - initial release
// ============================================================================

package mem_pkg;
    // Width of a packet-buffer pointer.
    localparam int ADDR_W = 12;
endpackage

package voq_pkg;
    // Number of entries held by each VOQ.
    localparam int VOQ_DEPTH = 4;
endpackage

module voq_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int VOQ_DEPTH = voq_pkg::VOQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         voq_write_req_i,
    output logic [NUM_PORTS-1:0]         voq_read_req_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]  voq_ptr_i,
    input  logic [NUM_PORTS-1:0]         voq_ptr_valid_i,
    output logic [ADDR_W-1:0]            ptr_o,
    output logic [$clog2(NUM_PORTS)-1:0] port_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [7:0]                   err_cnt_o
);

    localparam int c_PORT_W = $clog2(NUM_PORTS);
    localparam int c_CNT_W  = $clog2(VOQ_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [c_PORT_W-1:0]                 sel_q, sel_d;
    logic [c_PORT_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [c_PORT_W-1:0]                 port_q, port_d;
    logic [ADDR_W-1:0]                   ptr_q, ptr_d;
    logic [NUM_PORTS-1:0][c_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]                w_nonzero;
    logic [NUM_PORTS-1:0]                w_inc;
    logic [NUM_PORTS-1:0]                w_dec;
    logic                                w_any;
    logic                                w_found;
    logic [c_PORT_W-1:0]                 w_pick;
    logic [c_PORT_W:0]                   w_idx;
    logic                                w_cap_valid;
    logic [ADDR_W-1:0]                   w_cap_ptr;

    // ------------------------------------------------------------------------
    // Occupancy shadow counters.
    // Kept in a block separate from the arbiter so that the read request
    // (which depends on the FSM) never feeds back into the pick logic within
    // the same cycle. The arbiter only ever looks at registered counts, so a
    // write snooped in the decision cycle is not part of that decision.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nonzero = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_nonzero[k] = (cnt_q[k] != '0);
        end
    end

    assign w_any = |w_nonzero;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // A read can only be issued to a non-empty VOQ; the guard keeps
            // the counter from ever wrapping below zero.
            w_dec[k] = voq_read_req_o[k] && (cnt_q[k] != '0);
            // A full VOQ drops the write unless it is being read this cycle,
            // which mirrors the VOQ's own accept rule.
            w_inc[k] = voq_write_req_i[k] &&
                       ((cnt_q[k] < c_CNT_W'(VOQ_DEPTH)) || voq_read_req_o[k]);
            if (w_inc[k] && !w_dec[k]) begin
                cnt_d[k] = cnt_q[k] + c_CNT_W'(1);
            end else if (!w_inc[k] && w_dec[k]) begin
                cnt_d[k] = cnt_q[k] - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first non-empty VOQ at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = rr_ptr_q;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = {1'b0, rr_ptr_q} + (c_PORT_W + 1)'(i);
            if (w_idx >= (c_PORT_W + 1)'(NUM_PORTS)) begin
                w_idx = w_idx - (c_PORT_W + 1)'(NUM_PORTS);
            end
            if (!w_found && w_nonzero[w_idx[c_PORT_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[c_PORT_W-1:0];
            end
        end
    end

    // Head pointer returned by the selected VOQ one cycle after the read.
    assign w_cap_valid = voq_ptr_valid_i[sel_q];
    assign w_cap_ptr   = voq_ptr_i[sel_q*ADDR_W +: ADDR_W];

    // ------------------------------------------------------------------------
    // FSM: next state and outputs.
    // IDLE -> READ -> CAPTURE -> OUT -> IDLE gives a 3-cycle decision-to-valid
    // latency and at most one pointer every 4 cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        rr_ptr_d       = rr_ptr_q;
        ptr_d          = ptr_q;
        port_d         = port_q;
        voq_read_req_o = '0;
        valid_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    sel_d   = w_pick;
                    state_d = S_READ;
                end
            end

            S_READ: begin
                voq_read_req_o[sel_q] = 1'b1;
                rr_ptr_d = (sel_q == c_PORT_W'(NUM_PORTS - 1)) ?
                           '0 : sel_q + c_PORT_W'(1);
                state_d  = S_CAPTURE;
            end

            S_CAPTURE: begin
                if (w_cap_valid) begin
                    ptr_d   = w_cap_ptr;
                    port_d  = sel_q;
                    state_d = S_OUT;
                end else begin
                    // Underrun: the VOQ had nothing to return; drop the slot.
                    state_d = S_IDLE;
                end
            end

            S_OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            ptr_q    <= '0;
            port_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            ptr_q    <= ptr_d;
            port_q   <= port_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign port_o = port_q;

    // ------------------------------------------------------------------------
    // Optional underrun counter.
    // ------------------------------------------------------------------------
`ifdef VOQ_SCHED_UNDERRUN_CNT_EN
    logic [7:0] err_cnt_q;
    logic       w_underrun;

    assign w_underrun = (state_q == S_CAPTURE) && !w_cap_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (w_underrun && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_voq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voq_scheduler
//  Description : Directed self-checking bench for voq_scheduler. A small
//                behavioural VOQ model per port (FIFO of pointers, read data
//                returned with a valid one cycle after the read request)
//                sits between the stimulus and the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voq_scheduler;

    localparam int NP    = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
`ifdef VOQ_SCHED_UNDERRUN_CNT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    voq_write_req;
    logic [NP-1:0]    voq_read_req;
    logic [NP*AW-1:0] voq_ptr;
    logic [NP-1:0]    voq_ptr_valid;
    logic [AW-1:0]    ptr;
    logic [1:0]       port;
    logic             valid;
    logic             ready;
    logic [7:0]       err_cnt;

    logic [AW-1:0]    wdata [NP];
    logic             kill;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    voq_scheduler #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .VOQ_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .voq_write_req_i (voq_write_req),
        .voq_read_req_o  (voq_read_req),
        .voq_ptr_i       (voq_ptr),
        .voq_ptr_valid_i (voq_ptr_valid),
        .ptr_o           (ptr),
        .port_o          (port),
        .valid_o         (valid),
        .ready_i         (ready),
        .err_cnt_o       (err_cnt)
    );

    // ---------------- VOQ model ----------------
    logic [AW-1:0] m_mem [NP][DEPTH];
    int            m_cnt [NP];
    int            m_rp  [NP];
    int            m_wp  [NP];
    logic [AW-1:0] m_ptr [NP];
    logic [NP-1:0] m_valid;
    logic [NP-1:0] m_pop;
    logic [NP-1:0] m_push;

    always_comb begin
        m_pop  = '0;
        m_push = '0;
        for (int k = 0; k < NP; k++) begin
            m_pop[k]  = voq_read_req[k] && (m_cnt[k] > 0);
            m_push[k] = voq_write_req[k] && ((m_cnt[k] < DEPTH) || m_pop[k]);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= '0;
            for (int k = 0; k < NP; k++) begin
                m_cnt[k] <= 0;
                m_rp[k]  <= 0;
                m_wp[k]  <= 0;
                m_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NP; k++) begin
                m_valid[k] <= m_pop[k];
                if (m_pop[k]) begin
                    m_ptr[k] <= m_mem[k][m_rp[k]];
                    m_rp[k]  <= (m_rp[k] + 1) % DEPTH;
                end
                if (m_push[k]) begin
                    m_mem[k][m_wp[k]] <= wdata[k];
                    m_wp[k]           <= (m_wp[k] + 1) % DEPTH;
                end
                m_cnt[k] <= m_cnt[k] + (m_push[k] ? 1 : 0) - (m_pop[k] ? 1 : 0);
            end
        end
    end

    always_comb begin
        voq_ptr = '0;
        for (int k = 0; k < NP; k++) begin
            voq_ptr[k*AW +: AW] = m_ptr[k];
        end
    end

    assign voq_ptr_valid = m_valid & ~{NP{kill}};

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input int k, input logic [AW-1:0] d);
        wdata[k]         = d;
        voq_write_req    = '0;
        voq_write_req[k] = 1'b1;
        step();
        voq_write_req    = '0;
    endtask

    task automatic push_mask(input logic [NP-1:0] mask, input logic [AW-1:0] base);
        for (int k = 0; k < NP; k++) begin
            wdata[k] = base + AW'(k);
        end
        voq_write_req = mask;
        step();
        voq_write_req = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " valid seen"}, 32'(valid), 32'd1);
    endtask

    // Waits for a grant, checks it and completes the handshake (ready=1).
    task automatic expect_grant(input string tag, input int exp_port, input logic [AW-1:0] exp_ptr);
        wait_valid(tag);
        chk({tag, " port"}, 32'(port), 32'(exp_port));
        chk({tag, " ptr"},  32'(ptr),  32'(exp_ptr));
        step();
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (valid === 1'b1) n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int extra;
        int n;

        rst           = 1'b1;
        ready         = 1'b1;
        kill          = 1'b0;
        voq_write_req = '0;
        for (int k = 0; k < NP; k++) wdata[k] = '0;
        step();
        step();

        // Reset state
        chk("rst valid",    32'(valid),        32'd0);
        chk("rst read_req", 32'(voq_read_req), 32'd0);
        chk("rst ptr",      32'(ptr),          32'd0);
        chk("rst port",     32'(port),         32'd0);
        chk("rst err",      32'(err_cnt),      32'd0);
        chk("rst cnt",      32'(dut.cnt_q),    32'd0);
        rst = 1'b0;

        // Single VOQ with latency check
        push1(2, 12'h010);              // counted; IDLE sees count>0 next cycle
        push1(2, 12'h011);              // decision edge: only first write counts
        chk("t1 READ req",   32'(voq_read_req), 32'b0100);
        chk("t1 READ valid", 32'(valid),        32'd0);
        step();
        chk("t1 CAP valid",  32'(valid),        32'd0);
        chk("t1 CAP req",    32'(voq_read_req), 32'd0);
        step();
        chk("t1 OUT valid",  32'(valid),        32'd1);
        chk("t1 OUT port",   32'(port),         32'd2);
        chk("t1 OUT ptr",    32'(ptr),          32'h010);
        step();
        chk("t1 after hs valid", 32'(valid), 32'd0);
        expect_grant("t1 second", 2, 12'h011);

        // Round robin from rr_ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_mask(4'b1011, 12'h100);
        expect_grant("rr a0", 0, 12'h100);
        expect_grant("rr a1", 1, 12'h101);
        expect_grant("rr a3", 3, 12'h103);
        push_mask(4'b1111, 12'h200);
        expect_grant("rr b0", 0, 12'h200);
        expect_grant("rr b1", 1, 12'h201);
        expect_grant("rr b2", 2, 12'h202);
        expect_grant("rr b3", 3, 12'h203);

        // Backpressure, with another VOQ filling meanwhile
        ready = 1'b0;
        push1(1, 12'h0AB);
        wait_valid("bp");
        voq_write_req = 4'b1000;
        wdata[3]      = 12'h0CD;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d valid", i),    32'(valid),        32'd1);
            chk($sformatf("bp%0d ptr", i),      32'(ptr),          32'h0AB);
            chk($sformatf("bp%0d port", i),     32'(port),         32'd1);
            chk($sformatf("bp%0d read_req", i), 32'(voq_read_req), 32'd0);
            step();
            voq_write_req = '0;
        end
        ready = 1'b1;
        step();
        chk("bp hs valid", 32'(valid), 32'd0);
        expect_grant("bp next", 3, 12'h0CD);

        // Full boundary: park the scheduler in OUT, overfill VOQ 0
        ready = 1'b0;
        push1(1, 12'h050);
        wait_valid("full park");
        for (int i = 0; i <= DEPTH; i++) begin
            push1(0, 12'h300 + AW'(i));
        end
        chk("full cnt sat", 32'(dut.cnt_q[0]), 32'(DEPTH));
        ready = 1'b1;
        expect_grant("full park", 1, 12'h050);
        for (int i = 0; i < DEPTH; i++) begin
            expect_grant($sformatf("full e%0d", i), 0, 12'h300 + AW'(i));
        end
        count_valid(12, extra);
        chk("full no extra", 32'(extra), 32'd0);
        chk("full cnt empty", 32'(dut.cnt_q[0]), 32'd0);

        // Underrun: suppress the pointer valid during CAPTURE
        push1(3, 12'h077);
        n = 0;
        while (voq_read_req !== 4'b1000 && n < 10) begin
            step();
            n++;
        end
        chk("ur read_req", 32'(voq_read_req), 32'b1000);
        kill = 1'b1;
        step();                         // CAPTURE
        step();                         // underrun evaluated here
        kill = 1'b0;
        count_valid(10, extra);
        chk("ur no valid", 32'(extra),         32'd0);
        chk("ur err_cnt",  32'(err_cnt),       32'(EXP_ERR));
        chk("ur cnt3",     32'(dut.cnt_q[3]),  32'd0);

        // Reset while in OUT
        ready = 1'b0;
        push_mask(4'b0101, 12'h0E0);
        wait_valid("mr");
        chk("mr port", 32'(port), 32'd0);
        rst = 1'b1;
        step();
        chk("mr valid",    32'(valid),        32'd0);
        chk("mr cnt",      32'(dut.cnt_q),    32'd0);
        chk("mr read_req", 32'(voq_read_req), 32'd0);
        chk("mr err",      32'(err_cnt),      32'd0);
        chk("mr ptr",      32'(ptr),          32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        count_valid(8, extra);
        chk("mr quiet", 32'(extra), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
